// File: rtl/barrel_shifter.sv
// Registered logical barrel shifter: log2(WIDTH) cascaded shift-by-2^k mux
// stages, zero fill, direction select, one output register.
module barrel_shifter #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic [SHW-1:0]   shamt,
  input  logic             dir,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;

  // Each stage either passes its word through or shifts it by 2^k, driven by
  // one shamt bit. A running variable keeps the cascade a single comb block.
  always_comb begin
    logic [WIDTH-1:0] stage_v;
    stage_v = in;
    for (int k = 0; k < SHW; k++) begin
      if (shamt[k]) begin
        if (dir) stage_v = stage_v << (1 << k);
        else     stage_v = stage_v >> (1 << k);
      end
    end
    out_d = stage_v;
  end

  always_ff @(posedge clk) begin
    if (rst) out_q <= '0;
    else     out_q <= out_d;
  end

  assign out = out_q;

endmodule

// File: tb/tb_barrel_shifter.sv
// Self-checking bench for barrel_shifter: directed cases from the test plan
// followed by a randomized back-to-back sweep with a mid-sweep reset pulse.
module tb_barrel_shifter;

  localparam int WIDTH = 8;
  localparam int SHW   = 3;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] in;
  logic [SHW-1:0]   shamt;
  logic             dir;
  logic [WIDTH-1:0] out;

  int n_checks;
  int n_errors;

  barrel_shifter #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk  (clk),
    .rst  (rst),
    .in   (in),
    .shamt(shamt),
    .dir  (dir),
    .out  (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end else begin
      $display("ok   %s: out=%b", tag, got);
    end
  endtask

  // Reference: arithmetic on integers, multiply/divide by 2^s, then truncate.
  function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] d,
                                                 input int s, input logic left);
    longint v;
    v = longint'(d);
    if (left) v = (v * (longint'(1) << s)) % (longint'(1) << WIDTH);
    else      v = v / (longint'(1) << s);
    return v[WIDTH-1:0];
  endfunction

  // Drive one set of inputs, clock it in, and check the registered result.
  task automatic op(input string tag, input logic r, input logic [WIDTH-1:0] d,
                    input logic [SHW-1:0] s, input logic left,
                    input logic [WIDTH-1:0] exp);
    rst   = r;
    in    = d;
    shamt = s;
    dir   = left;
    @(posedge clk);
    #1;
    check(tag, out, exp);
  endtask

  initial begin
    logic [WIDTH-1:0] d;
    logic [SHW-1:0]   s;
    logic             l;
    logic             r;
    logic [WIDTH-1:0] exp;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; in = '0; shamt = '0; dir = 1'b0;
    @(negedge clk);

    op("reset_c1",   1'b1, 8'hFF, 3'd3, 1'b1, 8'h00);
    op("reset_c2",   1'b1, 8'hFF, 3'd3, 1'b1, 8'h00);
    op("post_reset", 1'b0, 8'hFF, 3'd3, 1'b1, 8'hF8);
    op("zero_in",    1'b0, 8'b00000000, 3'd0, 1'b0, 8'b00000000);
    op("sh3_left",   1'b0, 8'b01100110, 3'd3, 1'b1, 8'b00110000);
    op("sh3_right",  1'b0, 8'b01100110, 3'd3, 1'b0, 8'b00001100);
    op("sh5_left",   1'b0, 8'b01110110, 3'd5, 1'b1, 8'b11000000);
    op("sh5_right",  1'b0, 8'b01110110, 3'd5, 1'b0, 8'b00000011);
    op("sh7_left",   1'b0, 8'b10000001, 3'd7, 1'b1, 8'b10000000);
    op("sh7_right",  1'b0, 8'b10000001, 3'd7, 1'b0, 8'b00000001);
    op("sh0_left",   1'b0, 8'b10000001, 3'd0, 1'b1, 8'b10000001);
    op("sh0_right",  1'b0, 8'b10000001, 3'd0, 1'b0, 8'b10000001);

    // All-ones boundaries for every shift amount in both directions.
    for (int i = 0; i < WIDTH; i++) begin
      op($sformatf("ones_left_%0d", i), 1'b0, '1, SHW'(i), 1'b1,
         ref_shift('1, i, 1'b1));
      op($sformatf("ones_right_%0d", i), 1'b0, '1, SHW'(i), 1'b0,
         ref_shift('1, i, 1'b0));
    end

    // Back-to-back random sweep with a one-cycle reset pulse in the middle.
    for (int i = 0; i < 300; i++) begin
      d = WIDTH'($urandom);
      s = SHW'($urandom_range(0, WIDTH - 1));
      l = 1'($urandom);
      r = (i == 150);
      exp = r ? '0 : ref_shift(d, int'(s), l);
      op($sformatf("sweep_%0d%s", i, r ? "_rst" : ""), r, d, s, l, exp);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
